neuron_mac: RTL

Parametrised successor to the fixed 32-bit neuron: one fully sequential neuron with configurable data width, fixed-point format and input/output fan-in/out. It has an internal signed multiply-accumulate datapath (one product per cycle), a selectable activation function, and a scan chain for weights and bias. It sits in a layer between upstream neurons (per-input req/ack) and downstream neurons (per-output req/ack). Scan chains of neighbouring neurons are daisy-chained.

---
 rtl/neuron_mac.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: one sequential neuron. It captures NUM_INPUTS activations through
// per-input req/ack handshakes and accumulates bias plus weighted sum, one
// product per cycle. It then applies the selected activation function and
// presents the result to downstream neurons through per-output req/ack pairs.
// Weights and bias load through a daisy-chainable scan chain.
// Optional build macro: NEURON_MAC_SAT_EN. When defined, the result saturates
// to DATA_W bits. When undefined, the result wraps to the low DATA_W bits.
module neuron_mac #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned NUM_OUTPUTS = NUM_INPUTS,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAC_W      = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         shift_i,
  input  logic [DATA_W-1:0]            scan_di,
  output logic [DATA_W-1:0]            scan_do,
  input  logic [DATA_W*NUM_INPUTS-1:0] actv_i,
  input  logic [NUM_INPUTS-1:0]        req_i,
  output logic [NUM_INPUTS-1:0]        ack_o,
  output logic [NUM_OUTPUTS-1:0]       req_o,
  input  logic [NUM_OUTPUTS-1:0]       ack_i,
  output logic [DATA_W-1:0]            output_o,
  input  logic [1:0]                   act_mode_i,
  output logic                         busy_o
);

  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(NUM_INPUTS + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic signed [ACC_W-1:0] ACT_ONE = ACC_W'(1) << FRAC_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_busy;
  logic signed [DATA_W-1:0]  r_w    [NUM_INPUTS];
  logic signed [DATA_W-1:0]  r_actv [NUM_INPUTS];
  logic signed [DATA_W-1:0]  r_bias;
  logic [DATA_W-1:0]         r_scan_do;
  logic [NUM_INPUTS-1:0]     r_cap;
  logic [NUM_INPUTS-1:0]     r_ack;
  logic [NUM_OUTPUTS-1:0]    r_ackm;
  logic [NUM_OUTPUTS-1:0]    r_req;
  logic [DATA_W-1:0]         r_out;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;

  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_bias_ext;
  logic signed [ACC_W-1:0]   w_y;
  logic signed [ACC_W-1:0]   w_act;
  logic [DATA_W-1:0]         w_out;

  assign scan_do  = r_scan_do;
  assign ack_o    = r_ack;
  assign req_o    = r_req;
  assign output_o = r_out;
  assign busy_o   = r_busy;

  // Signed product of the current activation/weight pair, widened to the accumulator
  always_comb begin
    w_prod     = r_actv[r_idx] * r_w[r_idx];
    w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    w_bias_ext = {{(ACC_W - DATA_W){r_bias[DATA_W-1]}}, r_bias};
  end

  // Rescale to Q format and apply the selected activation function
  always_comb begin
    w_y   = r_acc >>> FRAC_W;
    w_act = w_y;
    case (act_mode_i)
      2'b01: if (w_y[ACC_W-1]) w_act = '0;
      2'b10: if (w_y[ACC_W-1]) w_act = w_y >>> 3;
      2'b11: begin
        if (w_y[ACC_W-1])        w_act = '0;
        else if (w_y > ACT_ONE)  w_act = ACT_ONE;
      end
      default: w_act = w_y;
    endcase
  end

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  // Saturating reduction to DATA_W bits
  always_comb begin
    if (w_act > SAT_MAX)      w_out = SAT_MAX[DATA_W-1:0];
    else if (w_act < SAT_MIN) w_out = SAT_MIN[DATA_W-1:0];
    else                      w_out = w_act[DATA_W-1:0];
  end
`else
  logic w_unused_hi;

  // Wrapping reduction to DATA_W bits; upper bits are intentionally dropped
  always_comb begin
    w_out       = w_act[DATA_W-1:0];
    w_unused_hi = ^w_act[ACC_W-1:DATA_W];
  end
`endif

  // Scan chain, handshakes and IDLE/MAC/ACT/OUTPUT sequencing; shift overrides all
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_bias    <= '0;
      r_scan_do <= '0;
      r_cap     <= '0;
      r_ack     <= '0;
      r_ackm    <= '0;
      r_req     <= '0;
      r_out     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_w[i]    <= '0;
        r_actv[i] <= '0;
      end
    end else if (shift_i) begin
      r_w[0] <= scan_di;
      for (int i = 1; i < NUM_INPUTS; i++) r_w[i] <= r_w[i-1];
      r_bias    <= r_w[NUM_INPUTS-1];
      r_scan_do <= r_bias;
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_req     <= '0;
      r_ack     <= '0;
      r_cap     <= '0;
      r_ackm    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (req_i[i] && !r_cap[i]) begin
              r_actv[i] <= actv_i[DATA_W*i +: DATA_W];
              r_ack[i]  <= 1'b1;
            end
          end
          if (&(r_cap | req_i)) begin
            r_cap   <= '0;
            r_acc   <= w_bias_ext <<< FRAC_W;
            r_idx   <= '0;
            r_state <= S_MAC;
            r_busy  <= 1'b1;
          end else begin
            r_cap <= r_cap | req_i;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NUM_INPUTS - 1)) r_state <= S_ACT;
        end
        S_ACT: begin
          r_out   <= w_out;
          r_req   <= '1;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_req  <= r_req & ~ack_i;
          r_ackm <= r_ackm | ack_i;
          if (&(r_ackm | ack_i)) begin
            r_req   <= '0;
            r_ackm  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
